// File: rtl/dp_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the shared A/B/C datapath with a timed enable window.
// Optional: define GRANT_COUNT_EN to add the saturating 8-bit grant_cnt output.
module dp_rr_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   code_in,
  output logic [NREQ-1:0]     gnt,
  output logic [2:0]          dp_abc,
  output logic                dp_en,
  output logic                busy
`ifdef GRANT_COUNT_EN
  ,
  output logic [7:0]          grant_cnt
`endif
);

  // A hold of zero would never enable the datapath, so it is promoted to one cycle
  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int CW       = $clog2(HOLD_EFF + 1);
  localparam int PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_EFF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_RELEASE
  } state_t;

  state_t          r_state, w_state_next;
  logic [NREQ-1:0] r_gnt, w_gnt_next;
  logic [2:0]      r_abc, w_abc_next;
  logic            r_en, w_en_next;
  logic            r_busy, w_busy_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [PW-1:0]   r_ptr, w_ptr_next;
  logic [PW-1:0]   r_win, w_win_next;

  logic [2:0]      w_codes [NREQ];
  logic            w_found;
  logic [PW-1:0]   w_win;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_code
    assign w_codes[gi] = code_in[3*gi +: 3];
  end

  // First requester found after the pointer, wrapping modulo NREQ
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req[PW'(idx)]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_abc_next   = r_abc;
    w_en_next    = r_en;
    w_busy_next  = r_busy;
    w_cnt_next   = r_cnt;
    w_ptr_next   = r_ptr;
    w_win_next   = r_win;
    case (r_state)
      S_IDLE: begin
        w_busy_next = 1'b0;
        if (w_found) begin
          w_state_next = S_DRIVE;
          w_gnt_next   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
          w_abc_next   = w_codes[w_win];
          w_en_next    = 1'b1;
          w_busy_next  = 1'b1;
          w_cnt_next   = CW'(1);
          w_win_next   = w_win;
        end
      end
      S_DRIVE: begin
        // Abort and normal completion both leave through RELEASE
        if (!req[r_win] || (r_cnt >= HOLD_MAX)) begin
          w_state_next = S_RELEASE;
          w_gnt_next   = '0;
          w_en_next    = 1'b0;
          w_ptr_next   = r_win;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_RELEASE: begin
        w_state_next = S_IDLE;
        w_busy_next  = 1'b0;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_gnt_next   = '0;
        w_en_next    = 1'b0;
        w_busy_next  = 1'b0;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_abc   <= 3'b000;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= PW'(NREQ - 1);
      r_win   <= '0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_abc   <= w_abc_next;
      r_en    <= w_en_next;
      r_busy  <= w_busy_next;
      r_cnt   <= w_cnt_next;
      r_ptr   <= w_ptr_next;
      r_win   <= w_win_next;
    end
  end

  assign gnt    = r_gnt;
  assign dp_abc = r_abc;
  assign dp_en  = r_en;
  assign busy   = r_busy;

`ifdef GRANT_COUNT_EN
  logic [7:0] r_gcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gcnt <= 8'h00;
    end else if ((r_state == S_IDLE) && w_found && (r_gcnt != 8'hFF)) begin
      r_gcnt <= r_gcnt + 8'h01;
    end
  end

  assign grant_cnt = r_gcnt;
`endif

endmodule
